seven_segment_counter_mux: RTL and testbench

Parametrised multi-digit BCD seconds counter with a time-multiplexed seven-segment display driver. It is the next generation of the single-digit seconds display in the Tiny Tapeout top level. It adds:
- configurable digit count
- up/down counting
- parallel load
- a runtime-programmable tick period
- a blinking decimal point

It sits between the top-level pin wrapper and the display pins. `uo_out` carries segments and dp; `uio_out` carries digit selects.

---
 rtl/seven_segment_counter_mux.sv | 154 +++++++++++++++
 tb/tb_seven_segment_counter_mux.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_counter_mux.sv
// rtl/seven_segment_counter_mux.sv - multi-digit BCD seconds counter with multiplexed seven-segment drive
// Optional leading-zero blanking when SEG_ZERO_BLANK_EN is defined.
module seven_segment_counter_mux #(
    parameter int          DIGITS   = 4,
    parameter logic [23:0] PRESCALE = 24'd10_000_000,
    parameter int          SCAN_DIV = 10_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic [7:0]            cmp_in,
    output logic [6:0]            segments,
    output logic                  dp,
    output logic [DIGITS-1:0]     digit_sel,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  tick,
    output logic                  wrap
);

    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [23:0]          pre;
    logic [23:0]          compare;
    logic                 pre_last;
    logic [4*DIGITS-1:0]  bcd_step;
    logic [4*DIGITS-1:0]  load_sat;
    logic                 step_wrap;
    logic                 carry;

    logic [SCAN_W-1:0]    scan_cnt;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     next_idx;
    logic [3:0]           sel_digit;
    logic                 blank;
    logic [6:0]           seg_next;
    logic                 dp_next;

    function automatic logic [6:0] decode_digit(input logic [3:0] d);
        case (d)
            4'd0:    decode_digit = 7'h3F;
            4'd1:    decode_digit = 7'h06;
            4'd2:    decode_digit = 7'h5B;
            4'd3:    decode_digit = 7'h4F;
            4'd4:    decode_digit = 7'h66;
            4'd5:    decode_digit = 7'h6D;
            4'd6:    decode_digit = 7'h7D;
            4'd7:    decode_digit = 7'h07;
            4'd8:    decode_digit = 7'h7F;
            4'd9:    decode_digit = 7'h6F;
            default: decode_digit = 7'h00;
        endcase
    endfunction

    assign compare  = (cmp_in == 8'd0) ? PRESCALE : {6'b0, cmp_in, 10'b0};
    // >= so that shrinking cmp_in mid-period ticks on the very next edge
    assign pre_last = (pre >= compare - 24'd1);

    // Ripple carry/borrow across digits; a carry out of the top digit is a wrap
    always_comb begin
        bcd_step = bcd;
        carry    = 1'b1;
        load_sat = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (up_dn) begin
                    if (bcd[4*i +: 4] == 4'd9) begin
                        bcd_step[4*i +: 4] = 4'd0;
                    end else begin
                        bcd_step[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (bcd[4*i +: 4] == 4'd0) begin
                        bcd_step[4*i +: 4] = 4'd9;
                    end else begin
                        bcd_step[4*i +: 4] = bcd[4*i +: 4] - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            load_sat[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
        end
        step_wrap = carry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre  <= '0;
            bcd  <= '0;
            tick <= 1'b0;
            wrap <= 1'b0;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
            if (load) begin
                bcd <= load_sat;
                pre <= '0;
            end else if (en) begin
                if (pre_last) begin
                    pre  <= '0;
                    tick <= 1'b1;
                    wrap <= step_wrap;
                    bcd  <= bcd_step;
                end else begin
                    pre <= pre + 24'd1;
                end
            end
        end
    end

    // Display registers are loaded from next_idx so digit_sel, segments and dp move together
    always_comb begin
        next_idx = idx;
        if (scan_cnt == SCAN_LAST) begin
            next_idx = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
        sel_digit = bcd[4*next_idx +: 4];
`ifdef SEG_ZERO_BLANK_EN
        blank = (next_idx != '0);
        for (int i = 0; i < DIGITS; i++) begin
            if ((i >= int'(next_idx)) && (bcd[4*i +: 4] != 4'd0)) begin
                blank = 1'b0;
            end
        end
`else
        blank = 1'b0;
`endif
        seg_next = blank ? 7'h00 : decode_digit(sel_digit);
        dp_next  = (next_idx == '0) && (pre < (compare >> 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt  <= '0;
            idx       <= '0;
            digit_sel <= DIGITS'(1);
            segments  <= 7'h3F;
            dp        <= 1'b0;
        end else begin
            scan_cnt  <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + 1'b1;
            idx       <= next_idx;
            digit_sel <= DIGITS'(1) << next_idx;
            segments  <= seg_next;
            dp        <= dp_next;
        end
    end

endmodule

// File: tb/tb_seven_segment_counter_mux.sv
// tb/tb_seven_segment_counter_mux.sv - directed bench for seven_segment_counter_mux
module tb_seven_segment_counter_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        up_dn;
    logic        load;
    logic [15:0] load_val;
    logic [7:0]  cmp_in;
    logic [6:0]  segments;
    logic        dp;
    logic [3:0]  digit_sel;
    logic [15:0] bcd;
    logic        tick;
    logic        wrap;

    int n_checks = 0;
    int n_pass   = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    seven_segment_counter_mux #(
        .DIGITS   (4),
        .PRESCALE (24'd20),
        .SCAN_DIV (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .up_dn     (up_dn),
        .load      (load),
        .load_val  (load_val),
        .cmp_in    (cmp_in),
        .segments  (segments),
        .dp        (dp),
        .digit_sel (digit_sel),
        .bcd       (bcd),
        .tick      (tick),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic load_bcd(input logic [15:0] v);
        @(negedge clk);
        load     = 1'b1;
        load_val = v;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick !== 1'b1 && n < 3000);
    endtask

    task automatic test_reset;
        reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0; cmp_in = 8'd0;
        repeat (3) @(negedge clk);
        n_checks++; if (bcd !== 16'h0000) $display("FAIL reset_bcd act=%h exp=0000", bcd); else n_pass++;
        n_checks++; if (tick !== 1'b0) $display("FAIL reset_tick act=%b exp=0", tick); else n_pass++;
        n_checks++; if (wrap !== 1'b0) $display("FAIL reset_wrap act=%b exp=0", wrap); else n_pass++;
        n_checks++; if (digit_sel !== 4'b0001) $display("FAIL reset_sel act=%b exp=0001", digit_sel); else n_pass++;
        n_checks++; if (segments !== 7'h3F) $display("FAIL reset_seg act=%h exp=3f", segments); else n_pass++;
        n_checks++; if (dp !== 1'b0) $display("FAIL reset_dp act=%b exp=0", dp); else n_pass++;
    endtask

    // k counts edges after the reset edge; compare = 1024, SCAN_DIV = 4
    task automatic test_blink;
        int          bad [5];
        int          fk  [5];
        logic [15:0] fa  [5];
        logic [15:0] fe  [5];
        logic [15:0] act [5];
        logic [15:0] exp [5];
        string       nm  [5] = '{"blink_tick", "blink_bcd", "blink_dp", "blink_sel", "blink_seg"};
        for (int s = 0; s < 5; s++) begin bad[s] = 0; fk[s] = 0; fa[s] = '0; fe[s] = '0; end
        en = 1'b1; up_dn = 1'b1; cmp_in = 8'd1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 3100; k++) begin
            int idx;
            int v;
            @(negedge clk);
            idx = (k / 4) % 4;
            v   = (k - 1) / 1024;
            exp[0] = {15'd0, (k % 1024 == 0)};
            exp[1] = 16'(k / 1024);
            exp[2] = {15'd0, (idx == 0) && (((k - 1) % 1024) < 512)};
            exp[3] = 16'(1 << idx);
            if (idx == 0) exp[4] = {9'd0, seg_tab[v]};
`ifdef SEG_ZERO_BLANK_EN
            else          exp[4] = 16'h0000;
`else
            else          exp[4] = 16'h003F;
`endif
            act[0] = {15'd0, tick};
            act[1] = bcd;
            act[2] = {15'd0, dp};
            act[3] = {12'd0, digit_sel};
            act[4] = {9'd0, segments};
            for (int s = 0; s < 5; s++) begin
                if (act[s] !== exp[s]) begin
                    if (bad[s] == 0) begin fk[s] = k; fa[s] = act[s]; fe[s] = exp[s]; end
                    bad[s]++;
                end
            end
        end
        for (int s = 0; s < 5; s++) begin
            n_checks++;
            if (bad[s] !== 0)
                $display("FAIL %s bad_cycles=%0d first_cycle=%0d act=%h exp=%h", nm[s], bad[s], fk[s], fa[s], fe[s]);
            else n_pass++;
        end
    endtask

    task automatic test_up_wrap;
        int n;
        up_dn = 1'b1; en = 1'b1; cmp_in = 8'd1;
        load_bcd(16'h9999);
        wait_tick(n);
        n_checks++; if (n !== 1024) $display("FAIL upwrap_period act=%0d exp=1024", n); else n_pass++;
        n_checks++; if (bcd !== 16'h0000) $display("FAIL upwrap_bcd act=%h exp=0000", bcd); else n_pass++;
        n_checks++; if (wrap !== 1'b1) $display("FAIL upwrap_wrap act=%b exp=1", wrap); else n_pass++;
        @(negedge clk);
        n_checks++; if (wrap !== 1'b0) $display("FAIL upwrap_wrap_pulse act=%b exp=0", wrap); else n_pass++;
        n_checks++; if (tick !== 1'b0) $display("FAIL upwrap_tick_pulse act=%b exp=0", tick); else n_pass++;
    endtask

    task automatic test_down_borrow;
        int n;
        up_dn = 1'b0;
        load_bcd(16'h0100);
        wait_tick(n);
        n_checks++; if (bcd !== 16'h0099) $display("FAIL down_borrow_bcd act=%h exp=0099", bcd); else n_pass++;
        n_checks++; if (wrap !== 1'b0) $display("FAIL down_borrow_wrap act=%b exp=0", wrap); else n_pass++;
        load_bcd(16'h0000);
        wait_tick(n);
        n_checks++; if (bcd !== 16'h9999) $display("FAIL down_wrap_bcd act=%h exp=9999", bcd); else n_pass++;
        n_checks++; if (wrap !== 1'b1) $display("FAIL down_wrap_wrap act=%b exp=1", wrap); else n_pass++;
    endtask

    task automatic test_load_priority;
        int n;
        up_dn = 1'b1;
        load_bcd(16'h0000);
        repeat (1023) @(negedge clk);
        n_checks++; if (tick !== 1'b0) $display("FAIL prio_pre_tick act=%b exp=0", tick); else n_pass++;
        load = 1'b1; load_val = 16'h12AF;
        @(negedge clk);
        load = 1'b0;
        n_checks++; if (bcd !== 16'h1299) $display("FAIL prio_sat_bcd act=%h exp=1299", bcd); else n_pass++;
        n_checks++; if (tick !== 1'b0) $display("FAIL prio_tick act=%b exp=0", tick); else n_pass++;
        n_checks++; if (wrap !== 1'b0) $display("FAIL prio_wrap act=%b exp=0", wrap); else n_pass++;
        wait_tick(n);
        n_checks++; if (n !== 1024) $display("FAIL prio_pre_cleared act=%0d exp=1024", n); else n_pass++;
        n_checks++; if (bcd !== 16'h1300) $display("FAIL prio_next_bcd act=%h exp=1300", bcd); else n_pass++;
    endtask

    task automatic test_enable;
        int bad;
        int n;
        bad = 0;
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (tick !== 1'b0 || bcd !== 16'h1300) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL enable_hold bad_cycles=%0d exp=0", bad); else n_pass++;
        n_checks++; if (bcd !== 16'h1300) $display("FAIL enable_bcd act=%h exp=1300", bcd); else n_pass++;
        load_bcd(16'h0042);
        n_checks++; if (bcd !== 16'h0042) $display("FAIL enable_load act=%h exp=0042", bcd); else n_pass++;
        en = 1'b1;
        wait_tick(n);
        n_checks++; if (n !== 1024) $display("FAIL enable_resume_period act=%0d exp=1024", n); else n_pass++;
        n_checks++; if (bcd !== 16'h0043) $display("FAIL enable_resume_bcd act=%h exp=0043", bcd); else n_pass++;
    endtask

    task automatic test_prescale;
        int n;
        cmp_in = 8'd0;
        load_bcd(16'h0000);
        wait_tick(n);
        n_checks++; if (n !== 20) $display("FAIL prescale_first act=%0d exp=20", n); else n_pass++;
        wait_tick(n);
        n_checks++; if (n !== 20) $display("FAIL prescale_period act=%0d exp=20", n); else n_pass++;
        n_checks++; if (bcd !== 16'h0002) $display("FAIL prescale_bcd act=%h exp=0002", bcd); else n_pass++;
        cmp_in = 8'd2;
        load_bcd(16'h0000);
        repeat (1500) @(negedge clk);
        cmp_in = 8'd1;
        wait_tick(n);
        n_checks++; if (n !== 1) $display("FAIL cmp_shrink act=%0d exp=1", n); else n_pass++;
        n_checks++; if (bcd !== 16'h0001) $display("FAIL cmp_shrink_bcd act=%h exp=0001", bcd); else n_pass++;
    endtask

    task automatic test_scan;
        logic [6:0] exp_seg [4];
        logic [3:0] prev;
        int         n;
        exp_seg[0] = 7'h6D;
        exp_seg[1] = 7'h3F;
        exp_seg[2] = 7'h07;
`ifdef SEG_ZERO_BLANK_EN
        exp_seg[3] = 7'h00;
`else
        exp_seg[3] = 7'h3F;
`endif
        en = 1'b0;
        load_bcd(16'h0705);
        n = 0;
        do begin
            prev = digit_sel;
            @(negedge clk);
            n++;
        end while (!(prev !== 4'b0001 && digit_sel === 4'b0001) && n < 40);
        n_checks++; if (n >= 40) $display("FAIL scan_sync timeout act=%0d exp=<40", n); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            if (i != 0) @(negedge clk);
            n_checks++;
            if (digit_sel !== 4'(1 << (i / 4)))
                $display("FAIL scan_sel cycle=%0d act=%b exp=%b", i, digit_sel, 4'(1 << (i / 4)));
            else n_pass++;
            n_checks++;
            if (segments !== exp_seg[i / 4])
                $display("FAIL scan_seg cycle=%0d act=%h exp=%h", i, segments, exp_seg[i / 4]);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++; if (digit_sel !== 4'b0001) $display("FAIL scan_rollover act=%b exp=0001", digit_sel); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int n;
        en = 1'b1; up_dn = 1'b1; cmp_in = 8'd1;
        load_bcd(16'h0042);
        n = 0;
        while (digit_sel !== 4'b0100 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++; if (digit_sel !== 4'b0100) $display("FAIL rstmid_sync act=%b exp=0100", digit_sel); else n_pass++;
        n_checks++; if (bcd !== 16'h0042) $display("FAIL rstmid_pre_bcd act=%h exp=0042", bcd); else n_pass++;
        reset = 1'b1; load = 1'b1; load_val = 16'h1234;
        @(negedge clk);
        reset = 1'b0; load = 1'b0;
        n_checks++; if (bcd !== 16'h0000) $display("FAIL rstmid_bcd act=%h exp=0000", bcd); else n_pass++;
        n_checks++; if (digit_sel !== 4'b0001) $display("FAIL rstmid_sel act=%b exp=0001", digit_sel); else n_pass++;
        n_checks++; if (segments !== 7'h3F) $display("FAIL rstmid_seg act=%h exp=3f", segments); else n_pass++;
        n_checks++; if (tick !== 1'b0) $display("FAIL rstmid_tick act=%b exp=0", tick); else n_pass++;
        n_checks++; if (wrap !== 1'b0) $display("FAIL rstmid_wrap act=%b exp=0", wrap); else n_pass++;
        n_checks++; if (dp !== 1'b0) $display("FAIL rstmid_dp act=%b exp=0", dp); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_blink;
        test_up_wrap;
        test_down_borrow;
        test_load_priority;
        test_enable;
        test_prescale;
        test_scan;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
